// File: rtl/pixel_writer.sv
// ---------------------------------------------------------------------------
// pixel_writer - queues on-screen drawer pixels and drains them, or a full-screen
// clear sweep, into the 160x120 framebuffer write port.          Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pixel_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [17:0] vga_colour,
  input  logic        vga_write,
  output logic        full,
  input  logic        clear_start,
  input  logic [17:0] clear_colour,
  output logic        clear_done,
  output logic        busy,
  output logic [7:0]  dropped_count,
  output logic [14:0] fb_address,
  output logic [17:0] fb_data,
  output logic        fb_wren,
  input  logic        fb_ready
);

  localparam int          c_aw        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          c_ew        = 8 + 7 + 18;
  localparam logic [14:0] c_last_addr = 15'(SCREEN_W * SCREEN_H - 1);
  localparam logic [7:0]  c_x_lim     = 8'(SCREEN_W);
  localparam logic [6:0]  c_y_lim     = 7'(SCREEN_H);
  localparam logic [c_aw:0] c_depth   = (c_aw + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [c_ew-1:0]   mem_q [FIFO_DEPTH];
  logic [c_aw-1:0]   wr_ptr_q;
  logic [c_aw-1:0]   rd_ptr_q;
  logic [c_aw:0]     count_q;
  logic              clear_pending_q;
  logic [17:0]       clear_colour_q;
  logic [14:0]       clr_addr_q;
  logic [7:0]        dropped_q;

  logic              on_screen;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [c_ew-1:0]   head;
  logic [7:0]        head_x;
  logic [6:0]        head_y;
  logic [17:0]       head_c;
  logic [14:0]       head_addr;
  logic              run_wr;

  assign on_screen  = (vga_x < c_x_lim) && (vga_y < c_y_lim);
  assign fifo_full  = (count_q == c_depth);
  assign fifo_empty = (count_q == '0);
  // A push that finds the FIFO full is lost even if a pop frees a slot this cycle.
  assign push       = vga_write && on_screen && !fifo_full;
  assign run_wr     = (state_q == ST_RUN) && !fifo_empty;
  assign pop        = run_wr && fb_ready;

  assign head      = mem_q[rd_ptr_q];
  assign head_x    = head[32:25];
  assign head_y    = head[24:18];
  assign head_c    = head[17:0];
  assign head_addr = {1'b0, head_y, 7'b0} + {3'b0, head_y, 5'b0} + {7'b0, head_x};

  always_comb begin
    fb_wren    = 1'b0;
    fb_address = '0;
    fb_data    = '0;
    if (state_q == ST_CLEAR) begin
      fb_wren    = 1'b1;
      fb_address = clr_addr_q;
      fb_data    = clear_colour_q;
    end else if (run_wr) begin
      fb_wren    = 1'b1;
      fb_address = head_addr;
      fb_data    = head_c;
    end
  end

  assign full          = fifo_full;
  assign clear_done    = (state_q == ST_DONE);
  assign busy          = !fifo_empty || clear_pending_q || (state_q != ST_RUN);
  assign dropped_count = dropped_q;

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {vga_x, vga_y, vga_colour};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_RUN;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      clear_pending_q <= 1'b0;
      clear_colour_q  <= '0;
      clr_addr_q      <= '0;
      dropped_q       <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (vga_write && on_screen && fifo_full && (dropped_q != 8'hFF)) begin
        dropped_q <= dropped_q + 1'b1;
      end

      case (state_q)
        ST_RUN: begin
          if (clear_pending_q && fifo_empty) begin
            state_q         <= ST_CLEAR;
            clr_addr_q      <= '0;
            clear_pending_q <= 1'b0;
          end else if (clear_start && !clear_pending_q) begin
            clear_pending_q <= 1'b1;
            clear_colour_q  <= clear_colour;
          end
        end
        ST_CLEAR: begin
          if (fb_ready) begin
            if (clr_addr_q == c_last_addr) begin
              state_q <= ST_DONE;
            end else begin
              clr_addr_q <= clr_addr_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/pixel_writer.md
# pixel_writer

Receiving end of the drawer-to-VGA pixel interface. Accepts single-pixel write strobes (x, y, colour, write) from the crosshair/wall/sprite drawers, discards off-screen coordinates, buffers accepted pixels in a small FIFO, and drains them into the 160x120 framebuffer memory port under a ready handshake. Also provides a hardware screen clear that sweeps every framebuffer address with one colour. Sits between the drawing FSMs and the framebuffer RAM.

## Interface

- FIFO_DEPTH, 8, pixel FIFO entries; power of two, 2..32
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- clock  in  1  global clock
- reset  in  1  synchronous, active-high reset
- vga_x  in  8  pixel column from drawer
- vga_y  in  7  pixel row from drawer
- vga_colour  in  18  pixel colour, 6 bits per channel
- vga_write  in  1  pixel write strobe; one pixel per cycle high
- full  out  1  FIFO holds FIFO_DEPTH entries
- clear_start  in  1  single-cycle request to clear the whole screen
- clear_colour  in  18  colour for clear; sampled on accepted clear_start
- clear_done  out  1  one-cycle pulse when the clear sweep completes
- busy  out  1  FIFO non-empty, clear pending, or clear in progress
- dropped_count  out  8  saturating count of pixels lost to FIFO overflow
- fb_address  out  15  framebuffer word address
- fb_data  out  18  framebuffer write data
- fb_wren  out  1  framebuffer write request
- fb_ready  in  1  framebuffer accepts write this cycle when high with fb_wren

## Operation

- Push: on a clock edge with vga_write=1: if vga_x>=SCREEN_W or vga_y>=SCREEN_H, pixel discarded silently (not counted); else if full=1, pixel discarded and dropped_count incremented (saturates at 255); else {x, y, colour} enqueued. Push while full is dropped even if a pop occurs in the same cycle.
- Address: fb_address = vga_y*160 + vga_x = (y<<7)+(y<<5)+x; range 0..19199, computed at dequeue, 15-bit.
- States: RUN, CLEAR, DONE.
- RUN: fb_wren = FIFO non-empty; fb_address/fb_data from FIFO head. Entry popped on the edge where fb_wren && fb_ready. Pixels leave in arrival order.
- clear_start=1 in RUN with no clear pending: set clear_pending, latch clear_colour. clear_start while pending, in CLEAR, or in DONE ignored.
- RUN -> CLEAR when clear_pending=1 and FIFO empty (pending pixels written first); clear counter set to 0, clear_pending cleared.
- CLEAR: fb_wren=1, fb_address=counter, fb_data=latched colour. Counter increments on each fb_ready. Drawer pushes still enqueue (up to full) but are not drained. After address 19199 accepted -> DONE.
- DONE: clear_done=1 for exactly one cycle, fb_wren=0; -> RUN. Queued pixels then drain over the cleared screen.
- busy = FIFO non-empty OR clear_pending OR state!=RUN.
- reset: state RUN, FIFO empty, clear_pending=0, counter=0. Outputs: full=0, busy=0, clear_done=0, dropped_count=0, fb_wren=0, fb_address=0, fb_data=0. Reset mid-clear aborts the sweep with no clear_done pulse; reset discards queued pixels.

## Timing

- Pixel pushed at edge t is visible on fb_* (fb_wren=1) during cycle t+1 if FIFO was empty and state RUN.
- With fb_ready held high, sustained throughput is one pixel per cycle; FIFO never fills.
- full asserts the cycle after the push that makes count=FIFO_DEPTH; deasserts the cycle after a pop from full.
- Clear sweep with fb_ready held high: 19200 write cycles, then one DONE cycle; clear_done at cycle 19201 after entering CLEAR.
- fb_ready low stalls the current head/clear address; fb_address and fb_data stay stable while fb_wren=1 and fb_ready=0.
- Crosshair drawer (5 writes, one every 2 cycles) never overflows a depth-8 FIFO with fb_ready=1.

## Test plan

- Single pixel x=10, y=5, colour=0x3F000, fb_ready=1 -> next cycle fb_wren=1, fb_address=810, fb_data=0x3F000, then fb_wren=0.
- Off-screen pushes (x=160,y=0) and (x=0,y=120) -> no fb_wren, dropped_count stays 0; (159,119) -> fb_address=19199.
- fb_ready=0, push 10 distinct pixels with FIFO_DEPTH=8 -> full=1 after 8th, dropped_count=2; release fb_ready -> first 8 written in order, then fb_wren=0.
- Push 3 pixels with fb_ready=0, pulse clear_start colour=0x00000, raise fb_ready -> 3 pixel writes, then addresses 0..19199 with data 0, clear_done one cycle, busy=0 after.
- During CLEAR push crosshair at (80,60) -> 5 writes (9680, 9520, 9681, 9840, 9679) appear only after clear_done, in that order.
- Assert reset at clear address 500 -> fb_wren=0 next cycle, no clear_done, busy=0, dropped_count=0; new clear_start restarts from address 0.
